// File: rtl/mac_lanes_pipe.sv
// Multi-lane pipelined signed MAC. Every lane multiplies its own in0 slice by the
// shared in1 operand and accumulates into a saturating accumulator. valid, clear
// and last travel in a shift register beside the products, so the accumulate
// decision always lines up with its product whatever MSTAGES is.

// One MAC lane: product pipeline, saturating accumulator, sticky overflow flag.
module mac_lane #(
  parameter int INW     = 16,
  parameter int OUTW    = 48,
  parameter int MSTAGES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INW-1:0]  a,
  input  logic [INW-1:0]  b,
  input  logic            tail_vld,
  input  logic            tail_clr,
  output logic [OUTW-1:0] acc,
  output logic            sat
);
  localparam int PW = 2 * INW;

  logic [MSTAGES-1:0][PW-1:0] prod_pipe;
  logic signed [PW-1:0]       a_x, b_x, prod_now;
  logic signed [OUTW-1:0]     prod_ext, acc_s, sum, clamp;
  logic                       ovf;

  // Operands are sign-extended to full product width, so the low PW bits of the
  // multiply are the exact signed product.
  assign a_x      = PW'(signed'(a));
  assign b_x      = PW'(signed'(b));
  assign prod_now = a_x * b_x;

  // Tail product sign-extended into the accumulator width.
  assign prod_ext = OUTW'(signed'(prod_pipe[MSTAGES-1]));
  assign acc_s    = signed'(acc);
  assign sum      = acc_s + prod_ext;
  // Overflow only when both addends share a sign and the sum leaves it.
  assign ovf      = (acc_s[OUTW-1] == prod_ext[OUTW-1]) && (sum[OUTW-1] != acc_s[OUTW-1]);
  assign clamp    = acc_s[OUTW-1] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};

  // Product shift register; stage 0 captures the multiply at the sampling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_pipe <= '0;
    end else begin
      prod_pipe[0] <= prod_now;
      for (int i = 1; i < MSTAGES; i++) prod_pipe[i] <= prod_pipe[i-1];
    end
  end

  // Accumulate at the pipeline tail; a clamped value keeps accumulating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (tail_vld && tail_clr) begin
      acc <= prod_ext;
      sat <= 1'b0;
    end else if (tail_vld) begin
      acc <= ovf ? clamp : sum;
      sat <= sat | ovf;
    end else if (tail_clr) begin
      acc <= '0;
      sat <= 1'b0;
    end
  end
endmodule

// Top: shared control pipeline plus LANES independent lane instances.
module mac_lanes_pipe #(
  parameter int INW     = 16,
  parameter int OUTW    = 48,
  parameter int LANES   = 4,
  parameter int MSTAGES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  clear_acc,
  input  logic                  last,
  input  logic [LANES*INW-1:0]  in0,
  input  logic [INW-1:0]        in1,
  output logic [LANES*OUTW-1:0] out,
  output logic                  out_valid,
  output logic [LANES-1:0]      sat
);
  logic [MSTAGES-1:0]            vld_pipe, clr_pipe, lst_pipe;
  logic [LANES-1:0][INW-1:0]     a_v;
  logic [LANES-1:0][OUTW-1:0]    acc_v;

  assign a_v = in0;
  assign out = acc_v;

  // Control bits shift alongside the products; bit MSTAGES-1 is the tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      clr_pipe <= '0;
      lst_pipe <= '0;
    end else begin
      vld_pipe <= MSTAGES'({vld_pipe, in_valid});
      clr_pipe <= MSTAGES'({clr_pipe, clear_acc});
      lst_pipe <= MSTAGES'({lst_pipe, last});
    end
  end

  // Completion pulse on the same edge that folds in a valid last item.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_valid <= 1'b0;
    else       out_valid <= vld_pipe[MSTAGES-1] & lst_pipe[MSTAGES-1];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(.INW(INW), .OUTW(OUTW), .MSTAGES(MSTAGES)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .a        (a_v[l]),
      .b        (in1),
      .tail_vld (vld_pipe[MSTAGES-1]),
      .tail_clr (clr_pipe[MSTAGES-1]),
      .acc      (acc_v[l]),
      .sat      (sat[l])
    );
  end
endmodule
